min_sec_timer: RTL

MIN_SEC_TIMER -- requirements
Module: min_sec_timer

---
 rtl/min_sec_timer_if.sv | 37 +++
 rtl/min_sec_timer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/min_sec_timer_if.sv
// Control and display bundle for min_sec_timer.
// MIN_SEC_TIMER_LAP_EN adds the lap pulse and lap_active status.
interface min_sec_timer_if;
   logic        start_stop;
   logic        load;
   logic [15:0] load_val;
   logic        count_down;
   logic [3:0]  d1_min;
   logic [3:0]  d0_min;
   logic [3:0]  d1_sec;
   logic [3:0]  d0_sec;
   logic        running;
   logic        done;
   logic        load_err;
`ifdef MIN_SEC_TIMER_LAP_EN
   logic        lap;
   logic        lap_active;

   modport master (
      output start_stop, load, load_val, count_down, lap,
      input  d1_min, d0_min, d1_sec, d0_sec, running, done, load_err, lap_active
   );
   modport slave (
      input  start_stop, load, load_val, count_down, lap,
      output d1_min, d0_min, d1_sec, d0_sec, running, done, load_err, lap_active
   );
`else
   modport master (
      output start_stop, load, load_val, count_down,
      input  d1_min, d0_min, d1_sec, d0_sec, running, done, load_err
   );
   modport slave (
      input  start_stop, load, load_val, count_down,
      output d1_min, d0_min, d1_sec, d0_sec, running, done, load_err
   );
`endif
endinterface

// File: rtl/min_sec_timer.sv
// MM:SS BCD up/down timer with run/pause/done control and validated BCD load.
// Optional lap freeze of the displayed digits when MIN_SEC_TIMER_LAP_EN is defined.
module min_sec_timer #(
   parameter int unsigned CYC_PER_SEC = 100000000,
   parameter int unsigned MAX_MIN     = 59,
   parameter bit          WRAP        = 1'b1
) (
   input logic            clk,
   input logic            rst,
   min_sec_timer_if.slave bus
);
   localparam int unsigned     PW       = $clog2(CYC_PER_SEC);
   localparam logic [PW-1:0]   PresLast = PW'(CYC_PER_SEC - 1);
   localparam logic [3:0]      MaxTens  = 4'(MAX_MIN / 10);
   localparam logic [3:0]      MaxOnes  = 4'(MAX_MIN % 10);

   typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

   state_e        state_q;
   logic [PW-1:0] presc_q;
   logic          down_q;
   logic [3:0]    m1_q, m0_q, s1_q, s0_q;
   logic          done_q, load_err_q;
`ifdef MIN_SEC_TIMER_LAP_EN
   logic          lap_q;
   logic [15:0]   frz_q;
`endif

   logic [3:0] m1_n, m0_n, s1_n, s0_n;
   logic       term, is_zero, load_ok, ss;
   logic [3:0] lv_m1, lv_m0, lv_s1, lv_s0;

   assign {lv_m1, lv_m0, lv_s1, lv_s0} = bus.load_val;
   assign is_zero = (m1_q == 4'd0) && (m0_q == 4'd0) && (s1_q == 4'd0) && (s0_q == 4'd0);
   assign ss      = bus.start_stop && !bus.load;
   assign load_ok = (lv_m1 <= 4'd9) && (lv_m0 <= 4'd9) && (lv_s1 <= 4'd5) && (lv_s0 <= 4'd9) &&
                    ((lv_m1 < MaxTens) || ((lv_m1 == MaxTens) && (lv_m0 <= MaxOnes)));

   // Next digit values for a one-second step; term flags the terminal count.
   always_comb begin
      {m1_n, m0_n, s1_n, s0_n} = {m1_q, m0_q, s1_q, s0_q};
      term = 1'b0;
      if (down_q) begin
         if (is_zero || ((m1_q == 4'd0) && (m0_q == 4'd0) && (s1_q == 4'd0) && (s0_q == 4'd1))) begin
            term = 1'b1;
            {m1_n, m0_n, s1_n, s0_n} = 16'h0000;
         end else if (s0_q != 4'd0) begin
            s0_n = s0_q - 4'd1;
         end else begin
            s0_n = 4'd9;
            if (s1_q != 4'd0) begin
               s1_n = s1_q - 4'd1;
            end else begin
               s1_n = 4'd5;
               if (m0_q != 4'd0) begin
                  m0_n = m0_q - 4'd1;
               end else begin
                  m0_n = 4'd9;
                  m1_n = m1_q - 4'd1;
               end
            end
         end
      end else begin
         if ((m1_q == MaxTens) && (m0_q == MaxOnes) && (s1_q == 4'd5) && (s0_q == 4'd9)) begin
            term = 1'b1;
            if (WRAP) {m1_n, m0_n, s1_n, s0_n} = 16'h0000;
         end else if (s0_q != 4'd9) begin
            s0_n = s0_q + 4'd1;
         end else begin
            s0_n = 4'd0;
            if (s1_q != 4'd5) begin
               s1_n = s1_q + 4'd1;
            end else begin
               s1_n = 4'd0;
               if (m0_q != 4'd9) begin
                  m0_n = m0_q + 4'd1;
               end else begin
                  m0_n = 4'd0;
                  m1_n = m1_q + 4'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         presc_q    <= '0;
         down_q     <= 1'b0;
         {m1_q, m0_q, s1_q, s0_q} <= 16'h0000;
         done_q     <= 1'b0;
         load_err_q <= 1'b0;
`ifdef MIN_SEC_TIMER_LAP_EN
         lap_q      <= 1'b0;
         frz_q      <= 16'h0000;
`endif
      end else begin
         done_q     <= 1'b0;
         load_err_q <= 1'b0;
         if (bus.load && load_ok) begin
            {m1_q, m0_q, s1_q, s0_q} <= bus.load_val;
            down_q  <= bus.count_down;
            state_q <= StIdle;
            presc_q <= '0;
`ifdef MIN_SEC_TIMER_LAP_EN
            lap_q   <= 1'b0;
`endif
         end else begin
            load_err_q <= bus.load;
`ifdef MIN_SEC_TIMER_LAP_EN
            if (bus.lap) begin
               if (lap_q) begin
                  lap_q <= 1'b0;
               end else if (state_q == StRun) begin
                  lap_q <= 1'b1;
                  frz_q <= {m1_q, m0_q, s1_q, s0_q};
               end
            end
`endif
            unique case (state_q)
               StRun: begin
                  if (presc_q == PresLast) begin
                     {m1_q, m0_q, s1_q, s0_q} <= {m1_n, m0_n, s1_n, s0_n};
                     presc_q <= '0;
                     done_q  <= term;
                     if (term && (down_q || !WRAP)) state_q <= StDone;
                     else if (ss)                   state_q <= StPause;
                  end else begin
                     presc_q <= presc_q + 1'b1;
                     if (ss) state_q <= StPause;
                  end
               end
               // A finished countdown sitting at 00:00 cannot be restarted.
               StDone: begin
                  if (ss && !(down_q && is_zero)) begin
                     state_q <= StRun;
                     presc_q <= '0;
                  end
               end
               default: begin
                  if (ss) begin
                     state_q <= StRun;
                     presc_q <= '0;
                  end
               end
            endcase
         end
      end
   end

`ifdef MIN_SEC_TIMER_LAP_EN
   assign {bus.d1_min, bus.d0_min, bus.d1_sec, bus.d0_sec} =
      lap_q ? frz_q : {m1_q, m0_q, s1_q, s0_q};
   assign bus.lap_active = lap_q;
`else
   assign {bus.d1_min, bus.d0_min, bus.d1_sec, bus.d0_sec} = {m1_q, m0_q, s1_q, s0_q};
`endif
   assign bus.running  = (state_q == StRun);
   assign bus.done     = done_q;
   assign bus.load_err = load_err_q;
endmodule
